// File: rtl/qualified_capture_pkg.sv
// Shared constants and helpers for the qualified capture buffer.
package qualified_capture_pkg;

  localparam int DROP_W = 8;

  // Pointer width carries one extra wrap bit above the index bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/capture_ptr.sv
// Wrap-bit pointer with increment enable and synchronous clear.
module capture_ptr #(
  parameter int PW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] ptr_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      ptr_reg <= '0;
    end else if (i_inc) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign o_ptr = ptr_reg;

endmodule

// File: rtl/qualified_capture.sv
// FIFO that captures i_data only when all three qualifiers are high,
// counting and flagging samples dropped while full.
module qualified_capture
  import qualified_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_a,
  input  logic                   i_b,
  input  logic                   i_c,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_clr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  output logic [DROP_W-1:0]      o_dropCount
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              qualify;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_count_reg;

  assign qualify = i_a && i_b && i_c;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A clear discards any same-cycle handshake; a pop frees the slot a full push needs.
  assign pop  = !empty && i_ready && !i_clr;
  assign push = qualify && !i_clr && (!full || pop);
  assign drop = qualify && !i_clr && full && !pop;

  capture_ptr #(.PW(PW)) u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_clr),
    .i_inc (push),
    .o_ptr (wr_ptr)
  );

  capture_ptr #(.PW(PW)) u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_clr),
    .i_inc (pop),
    .o_ptr (rd_ptr)
  );

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != {DROP_W{1'b1}}) begin
        drop_count_reg <= drop_count_reg + 1'b1;
      end
    end
  end

  // Storage is not reset, so the head is masked whenever nothing is buffered.
  assign o_valid     = !empty;
  assign o_data      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_level     = wr_ptr - rd_ptr;
  assign o_overflow  = overflow_reg;
  assign o_dropCount = drop_count_reg;

endmodule

// File: tb/tb_qualified_capture.sv
// Randomised and directed scoreboard bench for qualified_capture.
module tb_qualified_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_a = 1'b0, i_b = 1'b0, i_c = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_clr = 1'b0;
  logic             i_ready = 1'b0;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_level;
  logic             o_overflow;
  logic [7:0]       o_dropCount;

  qualified_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_c         (i_c),
    .i_data      (i_data),
    .i_clr       (i_clr),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_level     (o_level),
    .o_overflow  (o_overflow),
    .o_dropCount (o_dropCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: the buffer is just a bounded queue plus a drop tally.
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q [$];
  int               model_drops = 0;
  bit               model_ovf = 1'b0;
  int               peak_level = 0;
  int               last_pop = -1;
  bit               started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_update();
    int  size_before;
    bit  do_pop;
    if (i_rst || i_clr) begin
      model_q.delete();
      exp_q.delete();
      model_drops = 0;
      model_ovf   = 1'b0;
    end else begin
      size_before = model_q.size();
      do_pop = (size_before > 0) && i_ready;
      if (do_pop) void'(model_q.pop_front());
      if (i_a && i_b && i_c) begin
        if (size_before < DEPTH || do_pop) begin
          model_q.push_back(i_data);
          exp_q.push_back(i_data);
        end else begin
          model_ovf = 1'b1;
          if (model_drops < 255) model_drops++;
        end
      end
    end
  endtask

  task automatic check_state();
    chk("level", int'(o_level), model_q.size());
    chk("valid", int'(o_valid), (model_q.size() > 0) ? 1 : 0);
    chk("overflow", int'(o_overflow), int'(model_ovf));
    chk("drop_count", int'(o_dropCount), model_drops);
    if (int'(o_level) > peak_level) peak_level = int'(o_level);
  endtask

  task automatic step(input logic a, input logic b, input logic c, input logic [WIDTH-1:0] d,
                      input logic rdy, input logic clr, input logic rst);
    i_a = a; i_b = b; i_c = c; i_data = d; i_ready = rdy; i_clr = clr; i_rst = rst;
    @(posedge clk);
    model_update();
    #1;
    check_state();
  endtask

  // Monitor: consumes the scoreboard on every completed handshake.
  always @(negedge clk) begin
    if (started) begin
      if (!o_valid) chk("idle_data_zero", int'(o_data), 0);
      if (o_valid && i_ready && !i_clr && !i_rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", int'(o_data), -1);
        end else begin
          chk("pop_data", int'(o_data), int'(exp_q.pop_front()));
          last_pop = int'(o_data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    started = 1'b1;
    step(0, 0, 0, 8'h00, 0, 0, 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_level", int'(o_level), 0);

    // Streaming pass-through
    peak_level = 0;
    step(1, 1, 1, 8'h11, 1, 0, 0);
    step(1, 1, 1, 8'h22, 1, 0, 0);
    step(1, 1, 1, 8'h33, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1, 0, 0);
    chk("stream_peak", peak_level, 1);
    chk("stream_last", last_pop, 8'h33);

    // Partial qualification never captures
    for (int i = 0; i < 10; i++) step(1, 1, 0, 8'hAA, 1, 0, 0);
    chk("unqual_level", int'(o_level), 0);
    chk("unqual_valid", int'(o_valid), 0);

    // Overflow while stalled, then drain in order
    step(0, 0, 0, 8'h00, 0, 0, 1);
    for (int i = 1; i <= 6; i++) step(1, 1, 1, 8'(i), 0, 0, 0);
    chk("ovf_level", int'(o_level), 4);
    chk("ovf_flag", int'(o_overflow), 1);
    chk("ovf_drops", int'(o_dropCount), 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1, 0, 0);
    chk("drain_last", last_pop, 4);
    chk("drain_level", int'(o_level), 0);

    // Full with simultaneous push and pop
    step(0, 0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 8'(8'hA0 + i), 0, 0, 0);
    step(1, 1, 1, 8'h55, 1, 0, 0);
    chk("fullpp_level", int'(o_level), 4);
    chk("fullpp_drops", int'(o_dropCount), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1, 0, 0);
    chk("fullpp_last", last_pop, 8'h55);

    // Clear with a concurrent push
    for (int i = 0; i < 5; i++) step(1, 1, 1, 8'(8'hC0 + i), 0, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0, 0);
    chk("pre_clr_level", int'(o_level), 3);
    step(1, 1, 1, 8'hEE, 0, 1, 0);
    chk("clr_level", int'(o_level), 0);
    chk("clr_valid", int'(o_valid), 0);
    chk("clr_ovf", int'(o_overflow), 0);

    // Drop counter saturation, then reset with data buffered
    for (int i = 0; i < 4; i++) step(1, 1, 1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 1, 1, 8'hFF, 0, 0, 0);
    chk("sat_drops", int'(o_dropCount), 255);
    step(1, 1, 1, 8'h77, 1, 0, 1);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_data", int'(o_data), 0);
    chk("midrst_level", int'(o_level), 0);
    chk("midrst_ovf", int'(o_overflow), 0);
    chk("midrst_drops", int'(o_dropCount), 0);

    // Randomised traffic against the queue model
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
    end
    step(0, 0, 0, 8'h00, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qualified_capture.md
QUALIFIED_CAPTURE -- requirements
Module: qualified_capture

Interface
REQ-001 Parameter WIDTH, default 8: data width of captured samples, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: buffer entries, SHALL be a power of two >= 2.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_a, i_b, i_c  input  1 each  capture qualifiers; a sample is qualified only when all three are high in the same cycle.
REQ-006 i_data  input  WIDTH  sample captured when qualified.
REQ-007 i_clr  input  1  synchronous flush of buffer and status.
REQ-008 o_valid  output  1  head entry available downstream.
REQ-009 i_ready  input  1  downstream accepts head entry.
REQ-010 o_data  output  WIDTH  head entry value; SHALL be 0 when o_valid is low.
REQ-011 o_level  output  clog2(DEPTH)+1  current occupancy.
REQ-012 o_overflow  output  1  sticky: a qualified sample was dropped.
REQ-013 o_dropCount  output  8  number of dropped samples, saturating at 255.

Function
REQ-014 Qualify = i_a && i_b && i_c, computed combinationally; no capture otherwise, irrespective of i_data.
REQ-015 Push: qualified sample SHALL be written at cycle N and visible on o_data (if buffer was empty) with o_valid high at cycle N+1; latency exactly 1.
REQ-016 Pop: handshake completes on cycles where o_valid && i_ready; head SHALL advance at that edge.
REQ-017 o_valid SHALL not depend combinationally on i_ready; o_data/o_valid SHALL be stable while o_valid && !i_ready.
REQ-018 Order SHALL be strictly first-in-first-out.
REQ-019 Full (o_level == DEPTH) with push and no pop: sample dropped, o_overflow set, o_dropCount incremented (saturating).
REQ-020 Full with simultaneous push and pop: both SHALL succeed, level unchanged, no drop.
REQ-021 Empty with push and i_ready high: no pop occurs that cycle (o_valid low); entry appears next cycle.
REQ-022 Read/write pointers SHALL be clog2(DEPTH)+1 bits with wrap bit; full/empty derived from pointer compare, and o_level = wrPtr - rdPtr modulo 2^(clog2(DEPTH)+1).
REQ-023 i_clr SHALL take effect at the next edge: pointers equalised, level 0, o_overflow 0, o_dropCount 0; any push/pop in the same cycle SHALL be discarded.
REQ-024 Storage entries SHALL only be written on accepted pushes (enable-gated registers, no else-hold muxing on other paths).

Reset
REQ-025 On i_rst high at an edge: o_valid 0, o_data 0, o_level 0, o_overflow 0, o_dropCount 0, pointers 0.
REQ-026 i_rst SHALL take priority over i_clr, push and pop; reset mid-stream SHALL discard all buffered entries.
REQ-027 Storage array contents need not be reset; o_data SHALL still read 0 whenever o_valid is low.

Structure
REQ-028 Shared package qualified_capture_pkg SHALL hold the drop-counter width constant (8) and a function returning pointer width from DEPTH.
REQ-029 One sub-module, capture_ptr, SHALL implement a single wrap-bit pointer (increment enable, clear), instanced twice (read, write).
REQ-030 RTL SHALL be 120-400 lines total including the sub-module.

Verification
REQ-031 After reset, i_a=i_b=i_c=1, i_data=0x11,0x22,0x33 on consecutive cycles, i_ready=1 -> o_data 0x11,0x22,0x33 on the following three cycles, o_level peaks at 1.
REQ-032 i_a=1,i_b=1,i_c=0 with i_data=0xAA for 10 cycles -> o_valid stays 0, o_level 0.
REQ-033 DEPTH=4, i_ready=0, 6 qualified pushes -> o_level 4, o_overflow 1, o_dropCount 2; drain yields first 4 values in order.
REQ-034 Full buffer, push 0x55 with i_ready=1 same cycle -> no drop, o_level stays 4, 0x55 emerges last.
REQ-035 Buffer holding 3 entries, assert i_clr with simultaneous push -> next cycle o_level 0, o_valid 0, o_overflow 0.
REQ-036 300 drops at full -> o_dropCount saturates at 255; i_rst mid-stream -> all outputs at reset values next cycle.
